// File: rtl/sad_row_engine_pkg.sv
// Shared widths, constants and pipeline tag type for the SAD row engine.
package sad_row_engine_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int MV_W_DEF  = 14;
    localparam int SAD_W_DEF = 16;

    // Same all-ones value the MV selector uses to mark an empty slot
    localparam logic [SAD_W_DEF-1:0] SAD_ALL_ONES = '1;

    typedef struct packed {
        logic                valid;
        logic                first;
        logic                last;
        logic                grp_last;
        logic [MV_W_DEF-1:0] mv;
    } row_tag_t;

endpackage

// File: rtl/sad_row_engine_tree.sv
// Combinational per-pixel absolute difference and row adder tree.
// Difference and summation are split so the parent can register between them.
module sad_row_tree #(
    parameter int PIX_W = 8,
    parameter int N_PIX = 16
) (
    input  logic [N_PIX*PIX_W-1:0]          cur_row,
    input  logic [N_PIX*PIX_W-1:0]          ref_row,
    output logic [N_PIX*PIX_W-1:0]          diff_row,
    input  logic [N_PIX*PIX_W-1:0]          diff_q,
    output logic [PIX_W+$clog2(N_PIX)-1:0]  row_sum
);

    localparam int SUM_W  = PIX_W + $clog2(N_PIX);
    localparam int LEAVES = 1 << $clog2(N_PIX);

    for (genvar gi = 0; gi < N_PIX; gi++) begin : g_pix
        logic [PIX_W-1:0] c_pix;
        logic [PIX_W-1:0] r_pix;
        assign c_pix = cur_row[gi*PIX_W +: PIX_W];
        assign r_pix = ref_row[gi*PIX_W +: PIX_W];
        assign diff_row[gi*PIX_W +: PIX_W] = (c_pix >= r_pix) ? (c_pix - r_pix) : (r_pix - c_pix);
    end

    // Heap-ordered binary tree: node 1 is the root, leaves padded with zeros
    logic [SUM_W-1:0] node [1:2*LEAVES-1];

    always_comb begin
        for (int i = 1; i < 2*LEAVES; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < N_PIX; i++) begin
            node[LEAVES+i] = SUM_W'(diff_q[i*PIX_W +: PIX_W]);
        end
        for (int i = LEAVES - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
        row_sum = node[1];
    end

endmodule

// File: rtl/sad_row_engine.sv
// Three-stage SAD row accumulator feeding the motion-vector selector.
// Define SAD_ROW_ENGINE_SAT_EN to clamp overflowing SADs to all-ones instead of wrapping.
module sad_row_engine
    import sad_row_engine_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int N_PIX = 16,
    parameter int ROWS  = 16,
    parameter int SAD_W = SAD_W_DEF,
    parameter int MV_W  = MV_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     row_valid,
    input  logic [N_PIX*PIX_W-1:0]   cur_row,
    input  logic [N_PIX*PIX_W-1:0]   ref_row,
    input  logic [MV_W-1:0]          mv_in,
    input  logic                     grp_last_in,
    output logic                     sad_valid,
    output logic [SAD_W-1:0]         sad_out,
    output logic [MV_W-1:0]          mv_out,
    output logic                     grp_last_out,
    output logic                     busy
);

    localparam int CNT_W = $clog2(ROWS);
    localparam int RS_W  = PIX_W + $clog2(N_PIX);

    logic [CNT_W-1:0]       cnt_reg;
    logic [N_PIX*PIX_W-1:0] diff_row;
    logic [N_PIX*PIX_W-1:0] diff_reg;
    logic [RS_W-1:0]        row_sum;
    logic [RS_W-1:0]        row_sum_reg;
    row_tag_t               s1_tag_reg;
    row_tag_t               s2_tag_reg;
    logic [SAD_W-1:0]       acc_reg;
    logic [SAD_W-1:0]       acc_next;
    logic                   sad_valid_reg;
    logic [SAD_W-1:0]       sad_out_reg;
    logic [MV_W-1:0]        mv_out_reg;
    logic                   grp_last_out_reg;
    logic                   cnt_first;
    logic                   cnt_last;

    assign cnt_first = (cnt_reg == '0);
    assign cnt_last  = (cnt_reg == CNT_W'(ROWS - 1));

    sad_row_tree #(
        .PIX_W (PIX_W),
        .N_PIX (N_PIX)
    ) u_tree (
        .cur_row  (cur_row),
        .ref_row  (ref_row),
        .diff_row (diff_row),
        .diff_q   (diff_reg),
        .row_sum  (row_sum)
    );

    // Stage 1: row counter, registered differences and candidate tags.
    // mv is held from row 0 so it travels with the candidate's last row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg    <= '0;
            diff_reg   <= '0;
            s1_tag_reg <= '0;
        end else begin
            s1_tag_reg.valid <= row_valid;
            if (row_valid) begin
                cnt_reg          <= cnt_reg + CNT_W'(1);
                diff_reg         <= diff_row;
                s1_tag_reg.first <= cnt_first;
                s1_tag_reg.last  <= cnt_last;
                if (cnt_first) begin
                    s1_tag_reg.mv <= MV_W_DEF'(mv_in);
                end
                if (cnt_last) begin
                    s1_tag_reg.grp_last <= grp_last_in;
                end
            end
        end
    end

    // Stage 2: row sum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_sum_reg <= '0;
            s2_tag_reg  <= '0;
        end else if (s1_tag_reg.valid) begin
            row_sum_reg <= row_sum;
            s2_tag_reg  <= s1_tag_reg;
        end else begin
            s2_tag_reg.valid <= 1'b0;
        end
    end

`ifdef SAD_ROW_ENGINE_SAT_EN
    localparam int EXT_W = ((RS_W > SAD_W) ? RS_W : SAD_W) + 1;
    logic [EXT_W-1:0] acc_ext;

    // Once clamped the sum stays clamped, since row sums are never negative
    always_comb begin
        acc_ext = EXT_W'(row_sum_reg);
        if (!s2_tag_reg.first) begin
            acc_ext = acc_ext + EXT_W'(acc_reg);
        end
        acc_next = (acc_ext > EXT_W'({SAD_W{1'b1}})) ? '1 : acc_ext[SAD_W-1:0];
    end
`else
    always_comb begin
        acc_next = SAD_W'(row_sum_reg);
        if (!s2_tag_reg.first) begin
            acc_next = acc_next + acc_reg;
        end
    end
`endif

    // Stage 3: accumulator and result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg          <= '0;
            sad_valid_reg    <= 1'b0;
            sad_out_reg      <= '0;
            mv_out_reg       <= '0;
            grp_last_out_reg <= 1'b0;
        end else begin
            sad_valid_reg <= s2_tag_reg.valid && s2_tag_reg.last;
            if (s2_tag_reg.valid) begin
                acc_reg <= acc_next;
                if (s2_tag_reg.last) begin
                    sad_out_reg      <= acc_next;
                    mv_out_reg       <= MV_W'(s2_tag_reg.mv);
                    grp_last_out_reg <= s2_tag_reg.grp_last;
                end
            end
        end
    end

    assign sad_valid    = sad_valid_reg;
    assign sad_out      = sad_out_reg;
    assign mv_out       = mv_out_reg;
    assign grp_last_out = grp_last_out_reg;
    assign busy         = (cnt_reg != '0) || s1_tag_reg.valid || s2_tag_reg.valid;

endmodule

// File: tb/tb_sad_row_engine.sv
// Randomised bench for sad_row_engine: default instance plus a 12-bit SAD instance.
`timescale 1ns/1ps
module tb_sad_row_engine;

    localparam int PIX_W   = 8;
    localparam int N_PIX   = 16;
    localparam int ROWS    = 16;
    localparam int SAD_W   = 16;
    localparam int SAD_W_N = 12;
    localparam int MV_W    = 14;
    localparam int ROW_W   = N_PIX * PIX_W;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               row_valid = 1'b0;
    logic [ROW_W-1:0]   cur_row = '0;
    logic [ROW_W-1:0]   ref_row = '0;
    logic [MV_W-1:0]    mv_in = '0;
    logic               grp_last_in = 1'b0;

    logic               sad_valid, grp_last_out, busy;
    logic [SAD_W-1:0]   sad_out;
    logic [MV_W-1:0]    mv_out;
    logic               sad_valid_n, grp_last_out_n, busy_n;
    logic [SAD_W_N-1:0] sad_out_n;
    logic [MV_W-1:0]    mv_out_n;

    always #5 clk = ~clk;

    sad_row_engine #(
        .PIX_W(PIX_W), .N_PIX(N_PIX), .ROWS(ROWS), .SAD_W(SAD_W), .MV_W(MV_W)
    ) dut (
        .clk(clk), .reset(reset), .row_valid(row_valid), .cur_row(cur_row), .ref_row(ref_row),
        .mv_in(mv_in), .grp_last_in(grp_last_in), .sad_valid(sad_valid), .sad_out(sad_out),
        .mv_out(mv_out), .grp_last_out(grp_last_out), .busy(busy)
    );

    sad_row_engine #(
        .PIX_W(PIX_W), .N_PIX(N_PIX), .ROWS(ROWS), .SAD_W(SAD_W_N), .MV_W(MV_W)
    ) dut_n (
        .clk(clk), .reset(reset), .row_valid(row_valid), .cur_row(cur_row), .ref_row(ref_row),
        .mv_in(mv_in), .grp_last_in(grp_last_in), .sad_valid(sad_valid_n), .sad_out(sad_out_n),
        .mv_out(mv_out_n), .grp_last_out(grp_last_out_n), .busy(busy_n)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
        end
    endtask

    // Reference: a candidate's SAD is the plain integer sum of |cur-ref| over all its pixels
    typedef struct {
        int due;
        int total;
        int mv;
        bit gl;
    } exp_t;

    exp_t exp_q[$];
    int   ridx    = 0;
    int   total   = 0;
    int   cand_mv = 0;

    function automatic int fit(input int t, input int w);
`ifdef SAD_ROW_ENGINE_SAT_EN
        return (t >= (1 << w)) ? (1 << w) - 1 : t;
`else
        return t % (1 << w);
`endif
    endfunction

    function automatic logic [ROW_W-1:0] fill_row(input int v);
        logic [ROW_W-1:0] row;
        for (int i = 0; i < N_PIX; i++) row[i*PIX_W +: PIX_W] = PIX_W'(v);
        return row;
    endfunction

    task automatic diff_rows(input int d, output logic [ROW_W-1:0] c, output logic [ROW_W-1:0] r);
        for (int i = 0; i < N_PIX; i++) begin
            int a;
            int b;
            a = $urandom_range(255, d);
            b = a - d;
            if ($urandom_range(0, 1) == 1) begin
                c[i*PIX_W +: PIX_W] = PIX_W'(b);
                r[i*PIX_W +: PIX_W] = PIX_W'(a);
            end else begin
                c[i*PIX_W +: PIX_W] = PIX_W'(a);
                r[i*PIX_W +: PIX_W] = PIX_W'(b);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            row_valid = 1'b0;
            cur_row   = {4{$urandom()}};
            ref_row   = {4{$urandom()}};
            mv_in     = MV_W'($urandom());
        end
    endtask

    task automatic drive_row(input logic [ROW_W-1:0] c, input logic [ROW_W-1:0] r, input int mv, input bit gl);
        int rs;
        @(posedge clk); #1;
        cur_row     = c;
        ref_row     = r;
        mv_in       = mv[MV_W-1:0];
        grp_last_in = gl;
        row_valid   = 1'b1;
        rs = 0;
        for (int i = 0; i < N_PIX; i++) begin
            int a;
            int b;
            a = int'(c[i*PIX_W +: PIX_W]);
            b = int'(r[i*PIX_W +: PIX_W]);
            rs += (a > b) ? a - b : b - a;
        end
        if (ridx == 0) begin
            total   = 0;
            cand_mv = mv;
        end
        total += rs;
        if (ridx == ROWS - 1) exp_q.push_back('{cyc + 3, total, cand_mv, gl});
        ridx = (ridx + 1) % ROWS;
    endtask

    // mode 0: fixed cur=a/ref=b, mode 1: random pixels with |diff|=a, mode 2: fully random
    task automatic run_cand(input int mode, input int a, input int b, input int mv, input bit gl,
                            input bit gaps, input int nrows);
        logic [ROW_W-1:0] c;
        logic [ROW_W-1:0] r;
        for (int row = 0; row < nrows; row++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            case (mode)
                0:       begin c = fill_row(a); r = fill_row(b); end
                1:       diff_rows(a, c, r);
                default: begin c = {4{$urandom()}}; r = {4{$urandom()}}; end
            endcase
            drive_row(c, r, (row == 0) ? mv : int'($urandom_range(0, 16383)),
                      (row == ROWS - 1) ? gl : bit'($urandom_range(0, 1)));
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        row_valid = 1'b0;
        reset     = 1'b0;
        exp_q.delete();
        ridx = 0;
        #1;
        check({tag, "_sad_valid"}, sad_valid, 0);
        check({tag, "_sad_out"}, sad_out, 0);
        check({tag, "_mv_out"}, mv_out, 0);
        check({tag, "_grp_last"}, grp_last_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_n_valid"}, sad_valid_n, 0);
        check({tag, "_n_busy"}, busy_n, 0);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Output monitor: every result strobe must land exactly on its scheduled cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    $display("result cycle %0d: sad=%0d sad12=%0d mv=0x%0h grp_last=%0b (model total %0d)",
                             cyc, sad_out, sad_out_n, mv_out, grp_last_out, e.total);
                    check("sad_valid", sad_valid, 1);
                    check("sad_out", sad_out, fit(e.total, SAD_W));
                    check("mv_out", mv_out, e.mv);
                    check("grp_last_out", grp_last_out, e.gl);
                    check("sad_valid_n", sad_valid_n, 1);
                    check("sad_out_n", sad_out_n, fit(e.total, SAD_W_N));
                    check("mv_out_n", mv_out_n, e.mv);
                end else if (sad_valid || sad_valid_n) begin
                    check("spurious_valid", {sad_valid, sad_valid_n}, 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle(2);
        @(posedge clk); #1;
        reset = 1'b1;

        // Reset in the middle of a candidate, then a known 0x10/0x00 block
        run_cand(2, 0, 0, 14'h0aaa, 1'b0, 1'b0, 5);
        do_reset("rst_mid");
        run_cand(0, 8'h10, 8'h00, 14'h0123, 1'b0, 1'b0, ROWS);
        idle(5);

        // Back-to-back candidates, diff 1 then diff 2, group ends on the second
        run_cand(1, 1, 0, 14'h0011, 1'b0, 1'b0, ROWS);
        run_cand(1, 2, 0, 14'h0022, 1'b1, 1'b0, ROWS);
        idle(5);

        // Worst-case pixels with random gaps between rows
        run_cand(0, 8'hFF, 8'h00, 14'h3fff, 1'b1, 1'b1, ROWS);
        idle(5);

        // Abort after row 7, then a fresh diff-3 candidate
        run_cand(1, 3, 0, 14'h0777, 1'b0, 1'b0, 8);
        #1 check("busy_mid_candidate", busy, 1);
        do_reset("rst_abort");
        run_cand(1, 3, 0, 14'h0333, 1'b0, 1'b0, ROWS);
        idle(5);

        // Both orders of a pixel pair that straddles the signed midpoint
        run_cand(0, 8'h05, 8'hFA, 14'h0505, 1'b0, 1'b0, ROWS);
        run_cand(0, 8'hFA, 8'h05, 14'h0fa0, 1'b1, 1'b0, ROWS);

        // Fully random candidates, some with gaps
        for (int k = 0; k < 8; k++) begin
            run_cand(2, 0, 0, $urandom_range(0, 16383), bit'($urandom_range(0, 1)), bit'(k % 2), ROWS);
        end

        for (int k = 0; k < 64 && exp_q.size() > 0; k++) idle(1);
        idle(4);
        check("drain_empty", exp_q.size(), 0);
        check("busy_idle", busy, 0);
        check("busy_idle_n", busy_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sad_row_engine.md
Name: sad_row_engine

Overview:
- Pipelined SAD engine directly upstream of the motion-vector selector.
- Per candidate: consumes one row of current-block pixels and one row of reference pixels per strobe, and accumulates |cur-ref| over ROWS rows.
- Emits a one-cycle result strobe carrying SAD, candidate MV and group-last flag, which feeds the selector's write-enable / SAD / MV / wait inputs.

Parameters:
PIX_W, 8, pixel bit width
N_PIX, 16, pixels per row (row bus = N_PIX*PIX_W bits)
ROWS, 16, rows per block; power of two, >= 2
SAD_W, 16, SAD output width
MV_W, 14, motion-vector tag width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
row_valid  in  1  current strobe carries a valid row pair
cur_row  in  N_PIX*PIX_W  current-block row, pixel 0 in LSBs
ref_row  in  N_PIX*PIX_W  reference-candidate row, same packing
mv_in  in  MV_W  candidate MV; sampled on row 0 of each candidate
grp_last_in  in  1  candidate is last of its group; sampled on row ROWS-1
sad_valid  out  1  one-cycle strobe: sad_out/mv_out/grp_last_out valid
sad_out  out  SAD_W  completed candidate SAD
mv_out  out  MV_W  MV tag of that candidate
grp_last_out  out  1  asserted with sad_valid for the group's final candidate
busy  out  1  a candidate is partially received or in the pipeline

Behaviour:
- Reset: all outputs 0, row counter 0, pipeline tags cleared, accumulator 0. Reset mid-candidate discards all partial state; the next row_valid is row 0.
- Row counter: log2(ROWS) bits; increments on each row_valid; wraps ROWS-1 -> 0. No other control. Gaps (row_valid low) are allowed anywhere.
- Stage 1 (edge after row_valid = t): register N_PIX absolute differences (PIX_W bits, unsigned). Tags registered alongside: valid, first (cnt==0), last (cnt==ROWS-1), mv, grp_last.
  - mv is captured when cnt==0. grp_last is captured when cnt==ROWS-1.
- Stage 2 (t+2): register the adder-tree row sum, width PIX_W+log2(N_PIX). Tags advance with it.
- Stage 3 (t+3):
  - Stage-2 valid with first set: acc <= rowsum.
  - Stage-2 valid, first clear: acc <= acc + rowsum.
  - Stage-2 invalid: acc holds.
- Output register, loaded at edge t+3 when stage-2 valid and last tag set:
  - sad_valid=1, sad_out = next acc value, mv_out and grp_last_out from the tags.
  - Otherwise sad_valid=0; sad_out/mv_out/grp_last_out hold their last values.
- Latency: sad_valid rises exactly 3 cycles after the row_valid carrying row ROWS-1.
- Throughput: one row per cycle. Row 0 of the next candidate may follow row ROWS-1 in the very next cycle; back-to-back sad_valid pulses are spaced ROWS cycles apart.
- Width: with defaults the maximum SAD is 256*255 = 65280 and fits in 16 bits. Narrower SAD_W follows the Optional Feature rule.
- busy = (cnt != 0) OR any stage valid.
- No backpressure: the downstream selector accepts every strobe.

Optional Feature:
- Macro: SAD_ROW_ENGINE_SAT_EN
- Defined: accumulator and row sum are computed one bit wider, and any result >= 2^SAD_W clamps to all-ones (e.g. 16'hFFFF). This keeps saturated candidates losing against valid ones in the selector.
- Undefined: accumulator wraps modulo 2^SAD_W. No extra logic.

Decomposition:
- Shared package holds:
  - default widths PIX_W, MV_W, SAD_W;
  - the SAD all-ones constant (same value the selector uses for empty slots);
  - a pipeline-tag struct typedef {valid, first, last, grp_last, mv}.
- One sub-module: sad_row_tree — combinational abs-diff plus adder tree for N_PIX pixels, parameterised on PIX_W/N_PIX. Pipeline registers live in the parent.

Test Plan:
- Reset low mid-run -> all outputs 0, busy 0. Release, then feed 16 rows of cur=all 8'h10, ref=all 8'h00, mv_in=14'h0123 -> one sad_valid 3 cycles after row 15; sad_out=16'h1000, mv_out=14'h0123.
- Two back-to-back candidates: A all diffs 1 (SAD 256), B all diffs 2 (SAD 512), grp_last_in=1 on B row 15 -> sad_valid pulses 16 cycles apart with 256 then 512; grp_last_out is 0 on the first pulse and 1 on the second.
- Random row_valid gaps, worst-case cur=8'hFF, ref=8'h00 -> sad_out=16'hFF00 and latency measured from row 15 is still 3.
- Reset asserted after row 7 of a candidate, then a fresh 16-row candidate with diff 3 -> single sad_valid with sad_out=768; no pulse from the aborted candidate.
- SAD_W=12, all diffs 255 -> with SAD_ROW_ENGINE_SAT_EN: sad_out=12'hFFF; without it: 65280 mod 4096 = 12'hF00.
- Signed-order check: per-pixel cur=8'h05, ref=8'hFA and the swapped pair -> both give SAD 245*256 = 62720.
